// File: rtl/axi_r_line_collector_if.sv
// rtl/axi_r_line_collector_if.sv - refill request, AXI R beat and line handshake bundle
//
// Purpose: groups the signals of the line collector into one bundle.
//   slave  modport: the collector (consumes requests and R beats, produces the line)
//   master modport: the bus / refill side that drives requests and beats and takes lines
// Signals:
//   req_valid, req_id, req_ready             refill request handshake
//   rid, rdata, rresp, rlast, rvalid, rready AXI R channel beat
//   line_valid, line_ready, line_data        assembled line handshake
//   line_err, line_perr                      bus error / protocol error flags
interface axi_r_line_collector_if #(
  parameter int XLEN  = 64,
  parameter int ID_W  = 4,
  parameter int BEATS = 4
);
  logic                    req_valid;
  logic [ID_W-1:0]         req_id;
  logic                    req_ready;

  logic [ID_W-1:0]         rid;
  logic [XLEN-1:0]         rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic                    line_valid;
  logic                    line_ready;
  logic [BEATS*XLEN-1:0]   line_data;
  logic                    line_err;
  logic                    line_perr;

  modport slave (
    input  req_valid, req_id, rid, rdata, rresp, rlast, rvalid, line_ready,
    output req_ready, rready, line_valid, line_data, line_err, line_perr
  );

  modport master (
    output req_valid, req_id, rid, rdata, rresp, rlast, rvalid, line_ready,
    input  req_ready, rready, line_valid, line_data, line_err, line_perr
  );
endinterface

// File: rtl/axi_r_line_collector.sv
// rtl/axi_r_line_collector.sv - collects one AXI R burst into a full cache line
//
// Purpose: accepts one refill request (expected ID), gathers BEATS beats of the
//   returning R burst into a line buffer and offers the line with valid/ready,
//   together with a bus-error flag (SLVERR/DECERR seen) and a protocol-error flag.
// Ports:
//   clk_i   clock
//   srst_i  synchronous active-high reset
//   bus     axi_r_line_collector_if.slave (request, R channel, line output)
// Configuration:
//   AXI_R_PROTO_CHK_EN  when defined, rid and rlast are checked and reported on
//                       line_perr, and rlast may end a burst early; when undefined
//                       the burst is exactly BEATS beats and line_perr is 0.
module axi_r_line_collector #(
  parameter int XLEN  = 64,
  parameter int ID_W  = 4,
  parameter int BEATS = 4
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  axi_r_line_collector_if.slave   bus
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_SLOT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [BEATS-1:0][XLEN-1:0]    line_q;
  logic                          err_q;
  logic                          line_valid_q;
  logic                          unused_bits;

`ifdef AXI_R_PROTO_CHK_EN
  logic [ID_W-1:0]               id_q;
  logic                          perr_q;
`endif

  // rready is only ever high in COLLECT, so every rvalid seen there is an accepted beat.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      line_valid_q <= 1'b0;
`ifdef AXI_R_PROTO_CHK_EN
      id_q         <= '0;
      perr_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cnt    <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
`ifdef AXI_R_PROTO_CHK_EN
            id_q   <= bus.req_id;
            perr_q <= 1'b0;
`endif
            state  <= COLLECT;
          end
        end

        COLLECT: begin
          if (bus.rvalid) begin
            line_q[cnt] <= bus.rdata;
            cnt         <= cnt + 1'b1;
            // SLVERR and DECERR both have the upper response bit set.
            if (bus.rresp[1]) err_q <= 1'b1;
`ifdef AXI_R_PROTO_CHK_EN
            if (bus.rid != id_q) perr_q <= 1'b1;
            if (cnt == LAST_SLOT) begin
              if (!bus.rlast) perr_q <= 1'b1;
              state        <= OUTPUT;
              line_valid_q <= 1'b1;
            end else if (bus.rlast) begin
              // Early end of burst: remaining slots keep their cleared value.
              perr_q       <= 1'b1;
              state        <= OUTPUT;
              line_valid_q <= 1'b1;
            end
`else
            if (cnt == LAST_SLOT) begin
              state        <= OUTPUT;
              line_valid_q <= 1'b1;
            end
`endif
          end
        end

        OUTPUT: begin
          if (bus.line_ready) begin
            state        <= IDLE;
            line_valid_q <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          line_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshake readies come from the state register alone.
  assign bus.req_ready  = (state == IDLE);
  assign bus.rready     = (state == COLLECT);
  assign bus.line_valid = line_valid_q;
  assign bus.line_data  = line_q;
  assign bus.line_err   = err_q;

`ifdef AXI_R_PROTO_CHK_EN
  assign bus.line_perr  = perr_q;
  assign unused_bits    = bus.rresp[0];
`else
  assign bus.line_perr  = 1'b0;
  assign unused_bits    = ^{bus.rid, bus.rlast, bus.req_id, bus.rresp[0]};
`endif

endmodule

// File: tb/tb_axi_r_line_collector.sv
// tb/tb_axi_r_line_collector.sv - randomized bench for the AXI R line collector
module tb_axi_r_line_collector;
  localparam int XLEN  = 64;
  localparam int ID_W  = 4;
  localparam int BEATS = 4;
  localparam int LW    = XLEN * BEATS;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] data;
    logic [1:0]      resp;
    logic            last;
  } beat_t;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  beat_t beats[$];
  int    gap_pat[$];

  always #5 clk = ~clk;

  axi_r_line_collector_if #(.XLEN(XLEN), .ID_W(ID_W), .BEATS(BEATS)) bus ();

  axi_r_line_collector #(.XLEN(XLEN), .ID_W(ID_W), .BEATS(BEATS)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the beat list, the line ends at BEATS beats or (with checks) at the first rlast.
  task automatic model(input logic [ID_W-1:0] id, output logic [LW-1:0] line,
                       output logic e, output logic pe, output int n);
    line = '0;
    e    = 1'b0;
    pe   = 1'b0;
    n    = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (n == BEATS) break;
      line[n*XLEN +: XLEN] = beats[i].data;
      n++;
      if (beats[i].resp >= 2) e = 1'b1;
`ifdef AXI_R_PROTO_CHK_EN
      if (beats[i].id != id) pe = 1'b1;
      if (n == BEATS && !beats[i].last) pe = 1'b1;
      if (beats[i].last && n < BEATS) begin
        pe = 1'b1;
        break;
      end
`endif
    end
  endtask

  task automatic add_beat(input logic [ID_W-1:0] id, input logic [XLEN-1:0] d,
                          input logic [1:0] r, input logic l);
    beat_t b;
    b.id = id; b.data = d; b.resp = r; b.last = l;
    beats.push_back(b);
  endtask

  task automatic std_beats(input logic [ID_W-1:0] id);
    beats.delete();
    add_beat(id, 64'h1111_1111_1111_1111, 2'd0, 1'b0);
    add_beat(id, 64'h2222_2222_2222_2222, 2'd0, 1'b0);
    add_beat(id, 64'h3333_3333_3333_3333, 2'd0, 1'b0);
    add_beat(id, 64'h4444_4444_4444_4444, 2'd0, 1'b1);
  endtask

  task automatic rand_beats(input logic [ID_W-1:0] id);
    beats.delete();
    for (int i = 0; i < BEATS; i++) begin
      logic [ID_W-1:0] bid;
      logic [1:0]      br;
      logic            bl;
      bid = ($urandom_range(0, 7) == 0) ? ID_W'($urandom) : id;
      br  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      bl  = (i == BEATS - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      add_beat(bid, {$urandom, $urandom}, br, bl);
    end
  endtask

  // Runs one request from IDLE (called at a negedge) through the line handshake.
  task automatic burst(input logic [ID_W-1:0] id, input int hold, input bit b2b,
                       input logic [ID_W-1:0] next_id);
    logic [LW-1:0] el;
    logic          ee, epe;
    int            en, idx, cyc;
    bit            offer;
    logic          rr;
    model(id, el, ee, epe, en);
    bus.rvalid = 1'b0;
    chk("req_ready_idle", LW'(bus.req_ready), LW'(1'b1));
    chk("rready_idle", LW'(bus.rready), LW'(1'b0));
    bus.req_valid = 1'b1;
    bus.req_id    = id;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rready_collect", LW'(bus.rready), LW'(1'b1));
    idx = 0;
    cyc = 0;
    while (idx < en && cyc < 200) begin
      chk("no_early_valid", LW'(bus.line_valid), LW'(1'b0));
      rr = bus.rready;
      offer = (gap_pat.size() != 0) ? (gap_pat.pop_front() != 0) : ($urandom_range(0, 2) != 0);
      if (offer) begin
        bus.rid    = beats[idx].id;
        bus.rdata  = beats[idx].data;
        bus.rresp  = beats[idx].resp;
        bus.rlast  = beats[idx].last;
        bus.rvalid = 1'b1;
      end else begin
        bus.rvalid = 1'b0;
        bus.rdata  = {$urandom, $urandom};
      end
      @(posedge clk);
      if (bus.rvalid && rr) idx++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("beat_timeout", LW'(idx), LW'(en));
    bus.rvalid = 1'b0;
    chk("latency_valid", LW'(bus.line_valid), LW'(1'b1));
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", LW'(bus.line_valid), LW'(1'b1));
      chk("hold_rready", LW'(bus.rready), LW'(1'b0));
      chk("hold_req_ready", LW'(bus.req_ready), LW'(1'b0));
      chk("hold_data", bus.line_data, el);
      @(negedge clk);
    end
    chk("line_data", bus.line_data, el);
    chk("line_err", LW'(bus.line_err), LW'(ee));
    chk("line_perr", LW'(bus.line_perr), LW'(epe));
    bus.line_ready = 1'b1;
    if (b2b) begin
      bus.req_valid = 1'b1;
      bus.req_id    = next_id;
    end
    @(negedge clk);
    bus.line_ready = 1'b0;
    chk("post_hs_valid", LW'(bus.line_valid), LW'(1'b0));
    chk("post_hs_req_ready", LW'(bus.req_ready), LW'(1'b1));
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.rid        = '0;
    bus.rdata      = '0;
    bus.rresp      = 2'd0;
    bus.rlast      = 1'b0;
    bus.rvalid     = 1'b0;
    bus.line_ready = 1'b0;

    repeat (3) @(negedge clk);
    srst = 1'b0;
    chk("rst_req_ready", LW'(bus.req_ready), LW'(1'b1));
    chk("rst_rready", LW'(bus.rready), LW'(1'b0));
    chk("rst_line_valid", LW'(bus.line_valid), LW'(1'b0));
    chk("rst_err", LW'(bus.line_err), LW'(1'b0));
    chk("rst_perr", LW'(bus.line_perr), LW'(1'b0));
    chk("rst_data", bus.line_data, LW'(0));

    // Normal burst.
    std_beats(4'd3);
    burst(4'd3, 0, 1'b0, 4'd0);

    // Gapped rvalid and a held-off consumer.
    std_beats(4'd3);
    gap_pat = '{1, 0, 0, 1, 1, 0, 1};
    burst(4'd3, 5, 1'b0, 4'd0);

    // SLVERR on beat 2, then EXOKAY on beat 2.
    std_beats(4'd3);
    beats[1].resp = 2'd2;
    burst(4'd3, 1, 1'b0, 4'd0);
    std_beats(4'd3);
    beats[1].resp = 2'd1;
    burst(4'd3, 1, 1'b0, 4'd0);

    // Protocol cases: early rlast, wrong ID, missing rlast.
    std_beats(4'd3);
    beats[1].last = 1'b1;
    burst(4'd3, 2, 1'b0, 4'd0);
    std_beats(4'd3);
    beats[2].id = 4'd5;
    burst(4'd3, 0, 1'b0, 4'd0);
    std_beats(4'd3);
    beats[3].last = 1'b0;
    burst(4'd3, 0, 1'b0, 4'd0);

    // Reset after two beats, with a third still on the bus.
    std_beats(4'd2);
    bus.req_valid = 1'b1;
    bus.req_id    = 4'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.rid = beats[k].id; bus.rdata = beats[k].data;
      bus.rresp = beats[k].resp; bus.rlast = beats[k].last;
      bus.rvalid = 1'b1;
      @(negedge clk);
    end
    bus.rdata = beats[2].data;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("midrst_req_ready", LW'(bus.req_ready), LW'(1'b1));
    chk("midrst_rready", LW'(bus.rready), LW'(1'b0));
    chk("midrst_valid", LW'(bus.line_valid), LW'(1'b0));
    chk("midrst_data", bus.line_data, LW'(0));
    bus.rvalid     = 1'b0;
    bus.line_ready = 1'b1;
    @(negedge clk);
    bus.line_ready = 1'b0;
    chk("idle_line_ready_valid", LW'(bus.line_valid), LW'(1'b0));
    chk("idle_line_ready_req", LW'(bus.req_ready), LW'(1'b1));
    std_beats(4'd7);
    burst(4'd7, 0, 1'b0, 4'd0);

    // Back-to-back: erroneous burst followed by a clean one with req_valid held.
    std_beats(4'd3);
    beats[0].resp = 2'd3;
    beats[1].id   = 4'd9;
    burst(4'd3, 1, 1'b1, 4'd6);
    std_beats(4'd6);
    burst(4'd6, 0, 1'b0, 4'd0);

    // Randomized bursts, some chained back-to-back.
    begin
      logic [ID_W-1:0] cur_id;
      logic [ID_W-1:0] nxt_id;
      bit              chain;
      cur_id = ID_W'($urandom);
      for (int t = 0; t < 40; t++) begin
        nxt_id = ID_W'($urandom);
        chain  = ($urandom_range(0, 1) == 1) && (t != 39);
        rand_beats(cur_id);
        burst(cur_id, $urandom_range(0, 4), chain, nxt_id);
        cur_id = nxt_id;
        if (!chain) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/axi_r_line_collector.md
Name: axi_r_line_collector

Overview:
- Consumes beats from the slave side of the AXI R channel and assembles one burst into a full cache line for the cache refill path.
- Sits between the bus R channel and the L1 refill logic.
- Accepts one outstanding burst request at a time: expected ID plus start.
- Outputs the assembled line with valid/ready, plus a bus-error flag and a protocol-error flag.

Parameters:
- XLEN, 64, width of one R beat (rdata).
- ID_W, 4, width of rid and req_id (bus ID width).
- BEATS, 4, beats per line; power of two, >=2; line width = BEATS*XLEN.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- req_valid  in  1  refill request: a burst is about to return
- req_id  in  ID_W  ID expected on the returning beats
- req_ready  out  1  collector idle, can accept a request
- rid  in  ID_W  AXI R beat ID
- rdata  in  XLEN  AXI R beat data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last beat
- rvalid  in  1  AXI R beat valid
- rready  out  1  collector accepts a beat
- line_valid  out  1  assembled line available
- line_ready  in  1  consumer takes the line
- line_data  out  BEATS*XLEN  assembled line; beat k at bits [k*XLEN +: XLEN]
- line_err  out  1  a beat returned SLVERR or DECERR
- line_perr  out  1  protocol error: ID mismatch, early rlast or missing rlast

Behaviour:
- One clock domain, clk_i. srst_i is synchronous and active-high.
- Reset:
  - state=IDLE, beat counter=0, line buffer=0.
  - line_err=0, line_perr=0, line_valid=0, rready=0.
  - req_ready is 1 in the first cycle after srst_i deasserts.
- State IDLE:
  - req_ready=1, rready=0, line_valid=0.
  - On req_valid: latch req_id, clear counter, line buffer, err and perr; go to COLLECT.
- State COLLECT:
  - req_ready=0, rready=1.
  - Beat accepted when rvalid&rready.
  - Accepted beat: write rdata to line slot cnt, then cnt<=cnt+1.
  - Set err if rresp[1]=1 (SLVERR=2, DECERR=3). OKAY=0 and EXOKAY=1 do not set err.
  - Accepted beat with rid!=latched id: set perr; data is still stored.
  - rlast on a beat with cnt<BEATS-1: set perr, go to OUTPUT. Unfilled slots stay 0.
  - Beat with cnt==BEATS-1: go to OUTPUT. Set perr if rlast=0 on that beat.
  - Beats that follow a missing rlast belong to the external error path; the collector does not drain them.
- State OUTPUT:
  - line_valid=1, rready=0, req_ready=0.
  - line_data, line_err and line_perr hold stable until line_ready.
  - On line_valid&line_ready: go to IDLE. A new request is accepted no earlier than the next cycle.
- Latency: final beat accepted in cycle N gives line_valid=1 in cycle N+1, registered.
- Counter width is log2(BEATS). The counter never wraps inside a burst because COLLECT exits on the final beat.
- line_valid, line_err and line_perr are registered outputs. rready and req_ready are decoded from the state register only, with no combinational path from rvalid or line_ready.
- srst_i mid-burst:
  - Returns to IDLE immediately and discards the partial line.
  - Beats still in flight are ignored because rready=0 in IDLE.
- line_ready asserted while line_valid=0 has no effect.

Optional Feature:
- Macro: AXI_R_PROTO_CHK_EN.
- Defined:
  - rid comparison and rlast checks are active exactly as in Behaviour.
  - line_perr reflects violations.
- Undefined:
  - rid and rlast are ignored.
  - COLLECT exits only after BEATS accepted beats.
  - line_perr is tied to 0.
  - No ID register is implemented; req_id is unused.

Test Plan:
- Normal burst: req id=3; 4 beats id=3, data 0x11..,0x22..,0x33..,0x44.., rresp=0, rlast on beat 4.
  -> line_valid one cycle after beat 4; line_data[63:0]=0x11.., [255:192]=0x44..; err=0, perr=0.
- Backpressure on R:
  - rvalid gapped: 1,0,0,1,1,0,1.
  - -> 4 beats collected in order; line_valid one cycle after the last rvalid.
  - line_ready held 0 for 5 cycles -> line_valid and data stable; rready=0 throughout; req_ready=0 until the handshake.
- Error response: beat 2 has rresp=2 -> line_err=1, line_perr=0, all 4 beats stored.
  - Repeat with rresp=1 (EXOKAY) -> line_err=0.
- Protocol (macro defined):
  - rlast on beat 2 -> OUTPUT after 2 beats; slots 2-3 = 0; perr=1.
  - Beat 3 with id=5 against req id=3 -> perr=1.
  - Beat 4 with rlast=0 -> perr=1.
  - Macro undefined, same stimulus -> perr=0, 4 beats required.
- Reset mid-burst: srst_i after 2 beats -> next cycle IDLE, req_ready=1, rready=0, line_valid=0.
  - Following clean burst id=7 -> correct line, no residue from the prior burst.
- Back-to-back:
  - req_valid held 1 across the line handshake -> second request accepted exactly one cycle after line_valid&line_ready.
  - err and perr are cleared for the new burst.
